// File: rtl/soc_system_quad_reset_pkg.sv
// Shared types and register map for the quadrature-encoder reset sequencer.
package soc_system_quad_reset_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } chan_state_t;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_PWIDTH = 2'd1;
  localparam logic [1:0] ADDR_ARM    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STATUS_DONE_LSB = 16;

endpackage

// File: rtl/soc_system_quad_reset_chan.sv
// One encoder channel: IDLE -> PULSE -> HOLD FSM with width/holdoff counter
// and a depth-1 pending request flag.
module soc_system_quad_reset_chan
  import soc_system_quad_reset_pkg::*;
#(
  parameter int PW_W    = 16,
  parameter int HOLDOFF = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [PW_W-1:0] pw_load,
  output logic            quad_reset,
  output logic            busy,
  output logic            pending,
  output logic            done_set
);

  chan_state_t     state, state_nxt;
  logic [PW_W-1:0] cnt, cnt_nxt;
  logic            pend_nxt;
  logic            last;

  assign last = (cnt == PW_W'(1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      quad_reset <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pending    <= pend_nxt;
      quad_reset <= (state_nxt == PULSE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pending;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = PULSE;
          cnt_nxt   = pw_load;
        end
      end
      PULSE: begin
        cnt_nxt  = cnt - PW_W'(1);
        pend_nxt = pending | req;
        if (last) begin
          state_nxt = HOLD;
          cnt_nxt   = PW_W'(HOLDOFF);
          done_set  = 1'b1;
        end
      end
      HOLD: begin
        cnt_nxt  = cnt - PW_W'(1);
        pend_nxt = pending | req;
        // Queued work restarts straight out of the last hold cycle, so the
        // low gap between back-to-back pulses is exactly HOLDOFF.
        if (last) begin
          if (pending | req) begin
            state_nxt = PULSE;
            cnt_nxt   = pw_load;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/soc_system_quad_reset_sequencer.sv
// Avalon-MM reset-pulse sequencer for NUM_CH encoder counters.
// Optional interrupt output and mask register: define QUAD_RESET_IRQ_EN.
module soc_system_quad_reset_sequencer
  import soc_system_quad_reset_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int PW_W       = 16,
  parameter int PW_DEFAULT = 4,
  parameter int HOLDOFF    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [NUM_CH-1:0] index_in,
  output logic [NUM_CH-1:0] quad_reset
`ifdef QUAD_RESET_IRQ_EN
  ,
  output logic              irq
`endif
);

  if (NUM_CH < 1 || NUM_CH > 32 || PW_W < 1 || PW_W > 32 || HOLDOFF < 1 ||
      (HOLDOFF >> PW_W) != 0) begin : g_bad_cfg
    $error("soc_system_quad_reset_sequencer: bad NUM_CH/PW_W/HOLDOFF");
  end

  logic              wr;
  logic [PW_W-1:0]   pwidth, pw_load;
  logic [NUM_CH-1:0] arm, done_sticky, irq_mask, busy, pending, done_set, req;
  logic [NUM_CH-1:0] wd_hi, w1c;
  logic              unused_wd;

  assign wr        = chipselect & ~write_n;
  assign pw_load   = (pwidth == '0) ? PW_W'(1) : pwidth;
  assign req       = ({NUM_CH{wr && address == ADDR_CMD}} & writedata[NUM_CH-1:0])
                   | (arm & index_in);
  assign w1c       = (wr && address == ADDR_STATUS) ? wd_hi : '0;
  assign unused_wd = ^writedata;

  // Upper-half write bits (done W1C / irq mask); channels past bit 31 have none.
  always_comb begin
    wd_hi = '0;
    for (int j = 0; j < NUM_CH && j < 32 - STATUS_DONE_LSB; j++)
      wd_hi[j] = writedata[STATUS_DONE_LSB + j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwidth      <= PW_W'(PW_DEFAULT);
      arm         <= '0;
      done_sticky <= '0;
    end else begin
      if (wr && address == ADDR_PWIDTH) pwidth <= writedata[PW_W-1:0];
      // A same-cycle ARM write overrides the hardware clear on index fire.
      if (wr && address == ADDR_ARM) arm <= writedata[NUM_CH-1:0];
      else                           arm <= arm & ~index_in;
      done_sticky <= (done_sticky & ~w1c) | done_set;
    end
  end

`ifdef QUAD_RESET_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr && address == ADDR_ARM) irq_mask <= wd_hi;
      irq <= |(done_sticky & irq_mask);
    end
  end
`else
  assign irq_mask = '0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CMD:    readdata[NUM_CH-1:0] = pending;
      ADDR_PWIDTH: readdata[PW_W-1:0]   = pwidth;
      ADDR_ARM: begin
        readdata[NUM_CH-1:0] = arm;
        for (int j = 0; j < NUM_CH && j < 32 - STATUS_DONE_LSB; j++)
          readdata[STATUS_DONE_LSB + j] = irq_mask[j];
      end
      default: begin
        readdata[NUM_CH-1:0] = busy;
        for (int j = 0; j < NUM_CH && j < 32 - STATUS_DONE_LSB; j++)
          readdata[STATUS_DONE_LSB + j] = done_sticky[j];
      end
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    soc_system_quad_reset_chan #(
      .PW_W    (PW_W),
      .HOLDOFF (HOLDOFF)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .req        (req[i]),
      .pw_load    (pw_load),
      .quad_reset (quad_reset[i]),
      .busy       (busy[i]),
      .pending    (pending[i]),
      .done_set   (done_set[i])
    );
  end

endmodule

// File: tb/tb_soc_system_quad_reset_sequencer.sv
// Bench for soc_system_quad_reset_sequencer: directed steps then random traffic,
// checked against an interval-based model of pulse start times and holdoff windows.
`timescale 1ns/1ps
module tb_soc_system_quad_reset_sequencer;
  import soc_system_quad_reset_pkg::*;

  localparam int NUM_CH     = 8;
  localparam int PW_W       = 16;
  localparam int PW_DEFAULT = 4;
  localparam int HOLDOFF    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] index_in = '0;
  logic [NUM_CH-1:0] quad_reset;
`ifdef QUAD_RESET_IRQ_EN
  logic              irq;
`endif

  soc_system_quad_reset_sequencer #(
    .NUM_CH(NUM_CH), .PW_W(PW_W), .PW_DEFAULT(PW_DEFAULT), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .index_in   (index_in),
    .quad_reset (quad_reset)
`ifdef QUAD_RESET_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // Model: each channel remembers its latest pulse as (start edge, width);
  // it is free again once HOLDOFF edges have passed after the pulse ends.
  int                now = 0;
  bit                has_p  [NUM_CH];
  int                p_start[NUM_CH];
  int                p_w    [NUM_CH];
  bit                pend_m [NUM_CH];
  logic [NUM_CH-1:0] arm_m = '0, done_m = '0, mask_m = '0;
  int                pw_m = PW_DEFAULT;
  logic              irq_m = 1'b0;

  int                hi   [NUM_CH];
  int                rises[NUM_CH];
  logic [NUM_CH-1:0] prev_q = '0;

  function automatic logic [NUM_CH-1:0] exp_q();
    logic [NUM_CH-1:0] r = '0;
    for (int c = 0; c < NUM_CH; c++)
      r[c] = has_p[c] && now >= p_start[c] && now < p_start[c] + p_w[c];
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_busy();
    logic [NUM_CH-1:0] r = '0;
    for (int c = 0; c < NUM_CH; c++)
      r[c] = has_p[c] && now >= p_start[c] && now < p_start[c] + p_w[c] + HOLDOFF;
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [NUM_CH-1:0] pm = '0;
    for (int c = 0; c < NUM_CH; c++) pm[c] = pend_m[c];
    case (a)
      ADDR_CMD:    return 32'(pm);
      ADDR_PWIDTH: return 32'(pw_m);
      ADDR_ARM:    return 32'(arm_m) | (32'(mask_m) << 16);
      default:     return 32'(exp_busy()) | (32'(done_m) << 16);
    endcase
  endfunction

  task automatic check(input logic [1:0] a);
    logic [NUM_CH-1:0] eq;
    logic [31:0]       er;
    eq = exp_q();
    er = exp_rd(a);
    vectors++;
    assert (quad_reset === eq) else begin
      miscompares++;
      $error("FAIL quad_reset @%0d obs=%h exp=%h", now, quad_reset, eq);
    end
    vectors++;
    assert (readdata === er) else begin
      miscompares++;
      $error("FAIL readdata[a%0d] @%0d obs=%h exp=%h", a, now, readdata, er);
    end
`ifdef QUAD_RESET_IRQ_EN
    vectors++;
    assert (irq === irq_m) else begin
      miscompares++;
      $error("FAIL irq @%0d obs=%b exp=%b", now, irq, irq_m);
    end
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      if (quad_reset[c] === 1'b1) hi[c]++;
      if (quad_reset[c] === 1'b1 && prev_q[c] !== 1'b1) rises[c]++;
    end
    prev_q = quad_reset;
  endtask

  task automatic model_edge(input logic rst, input logic wr, input logic [1:0] a,
                            input logic [31:0] d, input logic [NUM_CH-1:0] idx);
    logic [NUM_CH-1:0] rq;
    int                ld, free_e;
    now++;
    irq_m = |(done_m & mask_m);
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin has_p[c] = 0; pend_m[c] = 0; end
      arm_m = '0; done_m = '0; mask_m = '0; pw_m = PW_DEFAULT; irq_m = 1'b0;
    end else begin
      if (wr && a == ADDR_STATUS) done_m &= ~d[16 +: NUM_CH];
      for (int c = 0; c < NUM_CH; c++)
        if (has_p[c] && now == p_start[c] + p_w[c]) done_m[c] = 1'b1;
      rq = ((wr && a == ADDR_CMD) ? d[NUM_CH-1:0] : '0) | (arm_m & idx);
      if (wr && a == ADDR_ARM) begin
        arm_m = d[NUM_CH-1:0];
`ifdef QUAD_RESET_IRQ_EN
        mask_m = d[16 +: NUM_CH];
`endif
      end else begin
        arm_m = arm_m & ~idx;
      end
      ld = (pw_m == 0) ? 1 : pw_m;
      for (int c = 0; c < NUM_CH; c++) begin
        free_e = has_p[c] ? p_start[c] + p_w[c] + HOLDOFF : 0;
        if ((pend_m[c] && now == free_e) || (rq[c] && now >= free_e)) begin
          has_p[c] = 1; p_start[c] = now; p_w[c] = ld; pend_m[c] = 0;
        end else if (rq[c]) begin
          pend_m[c] = 1;
        end
      end
      if (wr && a == ADDR_PWIDTH) pw_m = int'(d[PW_W-1:0]);
    end
  endtask

  task automatic cyc(input logic rst, input logic wr, input logic [1:0] a,
                     input logic [31:0] d, input logic [NUM_CH-1:0] idx);
    @(negedge clk);
    reset = rst; chipselect = 1'b1; write_n = ~wr;
    address = a; writedata = d; index_in = idx;
    #1;
    if (chk_on) check(a);
    @(posedge clk);
    model_edge(rst, wr, a, d, idx);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d, '0);
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, a, 32'h0, '0);
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < NUM_CH; c++) begin hi[c] = 0; rises[c] = 0; end
  endtask

  task automatic expect_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0]        ra;
    logic [31:0]       rd;
    logic [NUM_CH-1:0] ri;
    int                r;

    for (int c = 0; c < NUM_CH; c++) begin has_p[c] = 0; pend_m[c] = 0; p_start[c] = 0; p_w[c] = 0; end
    clr_cnt();

    // reset and register defaults
    cyc(1'b1, 1'b0, ADDR_CMD, 32'h0, '0);
    cyc(1'b1, 1'b0, ADDR_CMD, 32'h0, '0);
    chk_on = 1'b1;
    for (int a = 0; a < 4; a++) cyc(1'b0, 1'b0, 2'(a), 32'h0, '0);

    // 10-cycle pulses on ch0 and ch2, then W1C of their done bits
    wr_reg(ADDR_PWIDTH, 32'd10);
    clr_cnt();
    wr_reg(ADDR_CMD, 32'h05);
    idle(30, ADDR_STATUS);
    expect_int("ch0_width10", hi[0], 10);
    expect_int("ch2_width10", hi[2], 10);
    expect_int("ch1_idle", hi[1], 0);
    wr_reg(ADDR_STATUS, 32'h0005_0000);
    idle(2, ADDR_STATUS);

    // repeated CMD during a pulse merges into one extra pulse
    wr_reg(ADDR_PWIDTH, 32'd4);
    clr_cnt();
    wr_reg(ADDR_CMD, 32'h01);
    idle(1, ADDR_CMD);
    wr_reg(ADDR_CMD, 32'h01);
    idle(1, ADDR_CMD);
    wr_reg(ADDR_CMD, 32'h01);
    idle(50, ADDR_CMD);
    expect_int("merge_rises", rises[0], 2);
    expect_int("merge_hi", hi[0], 8);

    // armed index strobe fires once and disarms
    wr_reg(ADDR_ARM, 32'h02);
    clr_cnt();
    cyc(1'b0, 1'b0, ADDR_ARM, 32'h0, 8'h02);
    idle(25, ADDR_ARM);
    expect_int("index_pulse", hi[1], 4);
    clr_cnt();
    cyc(1'b0, 1'b0, ADDR_ARM, 32'h0, 8'h02);
    idle(25, ADDR_ARM);
    expect_int("index_disarmed", hi[1], 0);

    // CMD and index together give one pulse; ARM write beats the hardware clear
    wr_reg(ADDR_ARM, 32'h01);
    clr_cnt();
    cyc(1'b0, 1'b1, ADDR_CMD, 32'h01, 8'h01);
    idle(25, ADDR_ARM);
    expect_int("cmd_index_one", rises[0], 1);
    wr_reg(ADDR_ARM, 32'h01);
    clr_cnt();
    cyc(1'b0, 1'b1, ADDR_ARM, 32'h01, 8'h01);
    idle(25, ADDR_ARM);
    expect_int("rearm_pulse", rises[0], 1);
    wr_reg(ADDR_ARM, 32'h00);

    // PWIDTH=0 behaves as 1
    wr_reg(ADDR_PWIDTH, 32'd0);
    clr_cnt();
    wr_reg(ADDR_CMD, 32'h01);
    idle(20, ADDR_PWIDTH);
    expect_int("pw0_width", hi[0], 1);

    // reset in the middle of a 10-cycle pulse
    wr_reg(ADDR_PWIDTH, 32'd10);
    wr_reg(ADDR_CMD, 32'h01);
    idle(3, ADDR_STATUS);
    cyc(1'b1, 1'b0, ADDR_STATUS, 32'h0, '0);
    clr_cnt();
    idle(30, ADDR_STATUS);
    expect_int("reset_kills_pulse", hi[0], 0);

`ifdef QUAD_RESET_IRQ_EN
    wr_reg(ADDR_ARM, 32'h0001_0000);
    wr_reg(ADDR_CMD, 32'h01);
    idle(10, ADDR_STATUS);
    expect_int("irq_set", int'(irq), 1);
    wr_reg(ADDR_STATUS, 32'h0001_0000);
    idle(1, ADDR_STATUS);
    expect_int("irq_clear", int'(irq), 0);
    idle(20, ADDR_STATUS);
`endif

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      r  = int'($urandom_range(0, 199));
      ra = 2'($urandom_range(0, 3));
      rd = $urandom;
      if (ra == ADDR_PWIDTH) rd = $urandom_range(0, 12);
      ri = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
      cyc(r == 0, r >= 1 && r <= 40, ra, rd, ri);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
